// File: rtl/mips_bus_mem_responder_pkg.sv
// Shared bus types and constants for the MIPS CPU bus FSM, memory responders and benches.
// Pure declarations: no latency or backpressure of its own.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    localparam int          BUS_DATA_W = 32;
    localparam int          BUS_LANES  = 4;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Right-shifting Galois step; feedback taps are applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mips_bus_mem_responder_if.sv
// Avalon-style word bus between the MIPS CPU (master) and a memory responder (slave).
// The slave stalls the master through waitrequest; protocol_err reports master misbehaviour.
interface mips_bus_mem_responder_if;
    import mips_bus_pkg::*;

    logic [31:0]            address;
    logic                   read;
    logic                   write;
    logic [BUS_DATA_W-1:0]  writedata;
    logic [BUS_LANES-1:0]   byteenable;
    logic                   waitrequest;
    logic [BUS_DATA_W-1:0]  readdata;
    logic                   protocol_err;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, protocol_err
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, protocol_err
    );

endinterface

// File: rtl/mips_bus_mem_responder_lfsr16.sv
// 16-bit Galois LFSR that advances one step per cycle with step high; q is the current state.
// Loads seed on reset; no handshake.
module lfsr16
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Word-addressed memory responder: each request costs WAIT_CYCLES (+0..3 random) BUSY cycles then one ACK.
// waitrequest stays high from the accept cycle until ACK; the master must hold its request meanwhile.
module mips_bus_mem_responder
    import mips_bus_pkg::*;
#(
    parameter string       RAM_INIT_FILE   = "",
    parameter int          ADDR_WORDS_LOG2 = 11,
    parameter int          WAIT_CYCLES     = 1,
    parameter bit          RANDOM_STALL    = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic                      clk,
    input logic                      rst,
    mips_bus_mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
    localparam int CNT_W = $clog2(WAIT_CYCLES + 4);

    generate
        if (WAIT_CYCLES < 1) begin : g_bad_wait
            $error("mips_bus_mem_responder: WAIT_CYCLES must be at least 1");
        end
    endgenerate

    logic [BUS_DATA_W-1:0] mem [DEPTH];

    bus_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            addr_q, addr_d;
    logic [BUS_DATA_W-1:0]  wdata_q, wdata_d;
    logic [BUS_DATA_W-1:0]  rdata_q, rdata_d;
    logic [BUS_LANES-1:0]   be_q, be_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;

    logic                       accept;
    logic                       commit;
    logic [1:0]                 extra;
    logic [ADDR_WORDS_LOG2-1:0] idx;

    assign accept = (state_q == IDLE) && (bus.read || bus.write);
    assign commit = (state_q == BUSY) && (cnt_q == '0);
    assign idx    = addr_q[ADDR_WORDS_LOG2+1:2];

    generate
        if (RANDOM_STALL) begin : g_rand
            logic [15:0] lfsr_q;
            logic        unused_lfsr;

            lfsr16 u_lfsr (
                .clk  (clk),
                .rst  (rst),
                .step (accept),
                .seed (LFSR_SEED),
                .q    (lfsr_q)
            );

            assign extra       = lfsr_q[1:0];
            assign unused_lfsr = ^lfsr_q[15:2];
        end else begin : g_fixed
            logic unused_seed;

            assign extra       = 2'b00;
            assign unused_seed = ^LFSR_SEED;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = bus.address;
                    rd_d    = bus.read;
                    wr_d    = bus.write;
                    wdata_d = bus.writedata;
                    be_d    = bus.byteenable;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1) + CNT_W'(extra);
                    state_d = BUSY;
                    if (bus.read && bus.write) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // The master must hold its request unchanged; we finish with the latched copy regardless.
                if (bus.read != rd_q || bus.write != wr_q || bus.address != addr_q) begin
                    err_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ACK;
                    if (!wr_q) begin
                        rdata_d = mem[idx];
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Memory has no reset; a write only lands on the edge that leaves BUSY.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            for (int i = 0; i < BUS_LANES; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.waitrequest  = (state_q == IDLE) ? (bus.read || bus.write) : (state_q == BUSY);
    assign bus.readdata     = rdata_q;
    assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Directed bench for mips_bus_mem_responder: four instances (W=1, W=3, W=4, random stall)
// driven one at a time through a shared master stimulus mux.
module tb_mips_bus_mem_responder;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;

    logic [3:0]        wreq;
    logic [3:0]        perr;
    logic [3:0][31:0]  rdat;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_d
        localparam int WC = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 1;
        localparam bit RS = (g == 3);

        mips_bus_mem_responder_if bus ();

        assign bus.read       = (sel == g) && m_rd;
        assign bus.write      = (sel == g) && m_wr;
        assign bus.address    = m_addr;
        assign bus.writedata  = m_wdata;
        assign bus.byteenable = m_be;
        assign wreq[g]        = bus.waitrequest;
        assign perr[g]        = bus.protocol_err;
        assign rdat[g]        = bus.readdata;

        mips_bus_mem_responder #(
            .RAM_INIT_FILE   (""),
            .ADDR_WORDS_LOG2 (11),
            .WAIT_CYCLES     (WC),
            .RANDOM_STALL    (RS),
            .LFSR_SEED       (SEED)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        int          s;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          nw;
        logic [31:0] rdata;
        logic        perr;
    } vec_t;

    vec_t        tbl [14];
    int          nvec  = 0;
    int          nfail = 0;
    logic [15:0] lf;
    logic [31:0] sh  [8];
    int          rec [20];

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1; nw counts cycles with waitrequest high, -1 on timeout.
    task automatic xact(input int s, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output int nw);
        bit done;
        sel = s; m_rd = rd; m_wr = wr; m_addr = a; m_wdata = d; m_be = be;
        nw = 0; rdata = '0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (wreq[s]) nw++;
            else begin
                rdata = rdat[s];
                done  = 1'b1;
            end
        end
        if (!done) nw = -1;
        @(posedge clk); #1;
        m_rd = 1'b0; m_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lf = SEED;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          nw;
        int          ex;

        rst = 1'b1; sel = 0; m_rd = 1'b0; m_wr = 1'b0;
        m_addr = '0; m_wdata = '0; m_be = '0; lf = SEED;

        //             s  rd    wr    addr          wdata         be     nw exp rdata      perr
        tbl[0]  = '{0, 1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0};
        tbl[1]  = '{0, 1'b1, 1'b0, 32'hBFC00010, 32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{0, 1'b0, 1'b1, 32'h00000020, 32'h11223344, 4'hF, 2, 32'h0,        1'b0};
        tbl[3]  = '{0, 1'b0, 1'b1, 32'h00000020, 32'hAABBCCDD, 4'h5, 2, 32'h0,        1'b0};
        tbl[4]  = '{0, 1'b1, 1'b0, 32'h00000020, 32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0};
        tbl[5]  = '{0, 1'b0, 1'b1, 32'h00000020, 32'hFFFFFFFF, 4'h0, 2, 32'h0,        1'b0};
        tbl[6]  = '{0, 1'b1, 1'b0, 32'h00000023, 32'h0,        4'h0, 2, 32'h11BB33DD, 1'b0};
        tbl[7]  = '{1, 1'b0, 1'b1, 32'h00000000, 32'h00000A0A, 4'hF, 4, 32'h0,        1'b0};
        tbl[8]  = '{1, 1'b0, 1'b1, 32'h00001FFC, 32'h0000BEEF, 4'hF, 4, 32'h0,        1'b0};
        tbl[9]  = '{1, 1'b1, 1'b0, 32'h00000000, 32'h0,        4'h0, 4, 32'h00000A0A, 1'b0};
        tbl[10] = '{1, 1'b1, 1'b0, 32'h00001FFC, 32'h0,        4'h0, 4, 32'h0000BEEF, 1'b0};
        tbl[11] = '{1, 1'b1, 1'b0, 32'h00002000, 32'h0,        4'h0, 4, 32'h00000A0A, 1'b0};
        tbl[12] = '{0, 1'b1, 1'b1, 32'h00000040, 32'h12345678, 4'hF, 2, 32'h0,        1'b1};
        tbl[13] = '{0, 1'b1, 1'b0, 32'h00000040, 32'h0,        4'h0, 2, 32'h12345678, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            check($sformatf("reset waitrequest[%0d]", g), {31'b0, wreq[g]}, 32'h0);
            check($sformatf("reset readdata[%0d]", g), rdat[g], 32'h0);
            check($sformatf("reset protocol_err[%0d]", g), {31'b0, perr[g]}, 32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xact(tbl[i].s, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].be, rd, nw);
            check($sformatf("vec%0d wait cycles", i), 32'(nw), 32'(tbl[i].nw));
            if (tbl[i].rd && !tbl[i].wr)
                check($sformatf("vec%0d readdata", i), rd, tbl[i].rdata);
            check($sformatf("vec%0d protocol_err", i), {31'b0, perr[tbl[i].s]}, {31'b0, tbl[i].perr});
        end

        // Drop read in the middle of a W=3 transaction.
        sel = 1; m_rd = 1'b1; m_addr = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1 m_rd = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drop-read protocol_err set", {31'b0, perr[1]}, 32'h1);
        check("drop-read returns idle", {31'b0, wreq[1]}, 32'h0);
        check("drop-read other instance clean", {31'b0, perr[2]}, 32'h0);
        @(posedge clk); #1;
        xact(1, 1'b1, 1'b0, 32'h00001FFC, 32'h0, 4'h0, rd, nw);
        check("after drop-read data", rd, 32'h0000BEEF);
        check("after drop-read protocol_err sticky", {31'b0, perr[1]}, 32'h1);

        do_reset();
        @(negedge clk);
        check("rst clears protocol_err[0]", {31'b0, perr[0]}, 32'h0);
        check("rst clears protocol_err[1]", {31'b0, perr[1]}, 32'h0);
        @(posedge clk); #1;
        xact(0, 1'b1, 1'b0, 32'h00000020, 32'h0, 4'h0, rd, nw);
        check("committed write survives reset", rd, 32'h11BB33DD);

        // Reset in the middle of a W=4 write to word 5.
        xact(2, 1'b0, 1'b1, 32'h00000014, 32'h00000000, 4'hF, rd, nw);
        check("w4 init write wait cycles", 32'(nw), 32'd5);
        sel = 2; m_wr = 1'b1; m_addr = 32'h14; m_wdata = 32'hCAFEF00D; m_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("w4 busy before reset", {31'b0, wreq[2]}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; m_wr = 1'b0;
        #1 check("waitrequest falls on reset", {31'b0, wreq[2]}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; lf = SEED;
        xact(2, 1'b1, 1'b0, 32'h00000014, 32'h0, 4'h0, rd, nw);
        check("dropped write leaves word5", rd, 32'h00000000);
        check("w4 read wait cycles", 32'(nw), 32'd5);

        // Random stall: every transaction's length follows the seeded LFSR.
        for (int k = 0; k < 8; k++) begin
            sh[k] = 32'h5A5A0000 | (k * 32'h1111);
            ex = 2 + int'(lf[1:0]);
            lf = model_step(lf);
            xact(3, 1'b0, 1'b1, 32'(k * 4), sh[k], 4'hF, rd, nw);
            check($sformatf("rand write%0d wait", k), 32'(nw), 32'(ex));
        end
        for (int i = 0; i < 100; i++) begin
            int w;
            w  = (i * 3) % 8;
            ex = 2 + int'(lf[1:0]);
            lf = model_step(lf);
            xact(3, 1'b1, 1'b0, 32'(w * 4), 32'h0, 4'h0, rd, nw);
            check($sformatf("rand read%0d wait", i), 32'(nw), 32'(ex));
            check($sformatf("rand read%0d busy in 1..4", i), 32'(nw >= 2 && nw <= 5), 32'h1);
            check($sformatf("rand read%0d data", i), rd, sh[w]);
            if (i < 20) rec[i] = nw;
        end

        do_reset();
        for (int k = 0; k < 8; k++) begin
            xact(3, 1'b0, 1'b1, 32'(k * 4), sh[k], 4'hF, rd, nw);
        end
        for (int i = 0; i < 20; i++) begin
            xact(3, 1'b1, 1'b0, 32'(((i * 3) % 8) * 4), 32'h0, 4'h0, rd, nw);
            check($sformatf("rerun read%0d wait repeats", i), 32'(nw), 32'(rec[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
